// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: frames LEN_LO, LEN_HI and 4*N little-endian data bytes into
// instruction-memory word writes, holding the datapath in reset until the load completes.
// Optional trailing checksum byte is enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        imem_we_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] imem_wdata_o,
   output logic        cpu_reset_o,
   output logic        done_o,
   output logic        error_o
);

   localparam int unsigned LEN_W = 16;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef IMEM_BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CHK, S_RUN, S_ERR} state_e;
   localparam state_e S_END = S_CHK;
`else
   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_RUN, S_ERR} state_e;
   localparam state_e S_END = S_RUN;
`endif

   state_e           state_q;
   logic [7:0]       len_lo_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] idx_q;
   logic [1:0]       lane_q;
   logic [23:0]      word_q;
   logic [TMO_W-1:0] tmo_q;
   logic             imem_we_q;
   logic [31:0]      imem_addr_q;
   logic [31:0]      imem_wdata_q;
   logic             cpu_reset_q;
   logic             done_q;
   logic             error_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [7:0]       sum_q;
   logic [7:0]       sum_d;
`endif

   logic             load_state_c;
   logic             xfer_c;
   logic             tmo_run_c;
   logic             tmo_hit_c;
   logic             last_word_c;
   logic [LEN_W-1:0] len_d;
   logic [31:0]      word_d;
   logic [31:0]      addr_d;

   assign load_state_c = (state_q != S_RUN) && (state_q != S_ERR);
   assign xfer_c       = byte_valid_i && load_state_c;
   // Timeout window opens once LEN_LO is in and closes at S_RUN/S_ERR.
   assign tmo_run_c    = load_state_c && (state_q != S_LEN0);
   assign tmo_hit_c    = tmo_run_c && !xfer_c && (tmo_q == TMO_LAST);
   assign last_word_c  = (idx_q == (len_q - LEN_W'(1)));
   assign len_d        = {byte_data_i, len_lo_q};
   assign word_d       = {byte_data_i, word_q};
   assign addr_d       = BASE_ADDR + 32'({idx_q, 2'b00});
`ifdef IMEM_BOOT_CHECKSUM_EN
   assign sum_d        = sum_q + byte_data_i;
`endif

   assign byte_ready_o = load_state_c;
   assign imem_we_o    = imem_we_q;
   assign imem_addr_o  = imem_addr_q;
   assign imem_wdata_o = imem_wdata_q;
   assign cpu_reset_o  = cpu_reset_q;
   assign done_o       = done_q;
   assign error_o      = error_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_LEN0;
         len_lo_q     <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         lane_q       <= '0;
         word_q       <= '0;
         tmo_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= BASE_ADDR;
         imem_wdata_q <= '0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         imem_we_q <= 1'b0;

         // Release the datapath one cycle after entering S_RUN so the last write lands first.
         if (state_q == S_RUN) begin
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b1;
         end

         if (xfer_c) begin
            tmo_q <= '0;
         end else if (tmo_run_c) begin
            tmo_q <= tmo_q + TMO_W'(1);
         end

`ifdef IMEM_BOOT_CHECKSUM_EN
         if (xfer_c) begin
            sum_q <= sum_d;
         end
`endif

         case (state_q)
            S_LEN0: begin
               if (xfer_c) begin
                  len_lo_q <= byte_data_i;
                  state_q  <= S_LEN1;
               end
            end

            S_LEN1: begin
               if (xfer_c) begin
                  len_q <= len_d;
                  if (len_d > MAX_LEN) begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                  end else if (len_d == '0) begin
                     state_q <= S_END;
                  end else begin
                     state_q <= S_DATA;
                  end
               end else if (tmo_hit_c) begin
                  state_q <= S_ERR;
                  error_q <= 1'b1;
               end
            end

            S_DATA: begin
               if (xfer_c) begin
                  lane_q <= lane_q + 2'd1;
                  word_q <= word_d[31:8];
                  if (lane_q == 2'd3) begin
                     imem_we_q    <= 1'b1;
                     imem_addr_q  <= addr_d;
                     imem_wdata_q <= word_d;
                     idx_q        <= idx_q + LEN_W'(1);
                     if (last_word_c) begin
                        state_q <= S_END;
                     end
                  end
               end else if (tmo_hit_c) begin
                  state_q <= S_ERR;
                  error_q <= 1'b1;
               end
            end

`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHK: begin
               if (xfer_c) begin
                  if (sum_d == 8'h00) begin
                     state_q <= S_RUN;
                  end else begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                  end
               end else if (tmo_hit_c) begin
                  state_q <= S_ERR;
                  error_q <= 1'b1;
               end
            end
`endif

            S_RUN, S_ERR: begin
            end

            default: begin
               state_q <= S_ERR;
               error_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized frames,
// checked against a frame-level reference model (expected write list, done/error timing).
module tb_imem_boot_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int unsigned MAXW = 32;
   localparam int unsigned TMO  = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   always #5 clk = ~clk;

   imem_boot_loader #(
      .BASE_ADDR      (BASE),
      .MAX_WORDS      (MAXW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .byte_valid_i (byte_valid),
      .byte_data_i  (byte_data),
      .byte_ready_o (byte_ready),
      .imem_we_o    (imem_we),
      .imem_addr_o  (imem_addr),
      .imem_wdata_o (imem_wdata),
      .cpu_reset_o  (cpu_reset),
      .done_o       (done),
      .error_o      (error)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; every observed write strobe must match the next expected write.
   task automatic tick();
      @(posedge clk);
      #1;
      if (imem_we === 1'b1) begin
         chk("we_expected", 32'(exp_addr_q.size() != 0), 32'd1);
         if (exp_addr_q.size() != 0) begin
            chk("wr_addr", imem_addr, exp_addr_q.pop_front());
            chk("wr_data", imem_wdata, exp_data_q.pop_front());
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      chk("ready_load", 32'(byte_ready), 32'd1);
      byte_valid = 1'b1;
      byte_data  = b;
      tick();
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
   endtask

   task automatic check_reset_state();
      chk("rst_ready", 32'(byte_ready), 32'd1);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", imem_addr, BASE);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_cpurst", 32'(cpu_reset), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      byte_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_pending_writes", 32'(exp_addr_q.size()), 32'd0);
      exp_addr_q.delete();
      exp_data_q.delete();
      check_reset_state();
   endtask

   // Reference model: the frame bytes and expected writes follow directly from the word list.
   task automatic load_frame(input logic [31:0] words[$], input int min_gap, input int max_gap);
      logic [7:0] fb[$];
      logic [7:0] sum;
      int         n;
      n = words.size();
      fb.push_back(8'(n));
      fb.push_back(8'(n >> 8));
      foreach (words[i]) begin
         for (int k = 0; k < 4; k++) fb.push_back(8'(words[i] >> (8 * k)));
         exp_addr_q.push_back(BASE + 32'(4 * i));
         exp_data_q.push_back(words[i]);
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum = 8'h00;
      foreach (fb[i]) sum = sum + fb[i];
      fb.push_back(8'h00 - sum);
`else
      sum = 8'h00;
`endif
      foreach (fb[i]) begin
         send_byte(fb[i]);
         if (i != fb.size() - 1) begin
            chk("mid_error", 32'(error), 32'd0);
            repeat ($urandom_range(max_gap, min_gap)) tick();
         end
      end
      chk("frame_writes_done", 32'(exp_addr_q.size()), 32'd0);
      chk("t1_done", 32'(done), 32'd0);
      chk("t1_cpurst", 32'(cpu_reset), 32'd1);
      chk("t1_ready", 32'(byte_ready), 32'd0);
      tick();
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_cpurst", 32'(cpu_reset), 32'd0);
      chk("t2_error", 32'(error), 32'd0);
      byte_valid = 1'b1;
      repeat (3) tick();
      byte_valid = 1'b0;
      chk("run_ready", 32'(byte_ready), 32'd0);
      chk("run_done", 32'(done), 32'd1);
   endtask

   initial begin
      logic [31:0] w[$];
      logic [31:0] w0;
      logic [31:0] w1;
      int          len;
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;

      do_reset();

      // Back-to-back two-word frame
      w = '{32'h0000_0513, 32'h0010_0593};
      load_frame(w, 0, 0);

      // Same frame, 3 idle cycles between bytes
      do_reset();
      load_frame(w, 3, 3);

      // Empty frame
      do_reset();
      w.delete();
      load_frame(w, 0, 1);

      // Largest legal frame
      do_reset();
      w.delete();
      for (int i = 0; i < int'(MAXW); i++) w.push_back($urandom);
      load_frame(w, 0, 0);

      // Randomized frames
      for (int r = 0; r < 6; r++) begin
         do_reset();
         w.delete();
         len = $urandom_range(8, 1);
         for (int i = 0; i < len; i++) w.push_back($urandom);
         load_frame(w, 0, 3);
      end

      // Oversized length rejected: directed MAX+1, then random oversized
      for (int r = 0; r < 2; r++) begin
         do_reset();
         len = (r == 0) ? int'(MAXW) + 1 : $urandom_range(65535, MAXW + 1);
         send_byte(8'(len));
         send_byte(8'(len >> 8));
         chk("big_error", 32'(error), 32'd1);
         chk("big_ready", 32'(byte_ready), 32'd0);
         chk("big_cpurst", 32'(cpu_reset), 32'd1);
         chk("big_done", 32'(done), 32'd0);
         byte_valid = 1'b1;
         byte_data  = 8'h13;
         repeat (6) tick();
         byte_valid = 1'b0;
         chk("big_error_sticky", 32'(error), 32'd1);
         chk("big_we", 32'(imem_we), 32'd0);
      end

      // Timeout after a partial word, then recovery
      do_reset();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (TMO - 1) tick();
      chk("tmo_not_yet", 32'(error), 32'd0);
      chk("tmo_ready_still", 32'(byte_ready), 32'd1);
      tick();
      chk("tmo_error", 32'(error), 32'd1);
      chk("tmo_ready", 32'(byte_ready), 32'd0);
      chk("tmo_cpurst", 32'(cpu_reset), 32'd1);
      do_reset();
      w = '{$urandom};
      load_frame(w, 0, 2);

      // Reset collides with the 3rd byte of word 1
      do_reset();
      w0 = $urandom;
      w1 = $urandom;
      exp_addr_q.push_back(BASE);
      exp_data_q.push_back(w0);
      send_byte(8'h02);
      send_byte(8'h00);
      for (int k = 0; k < 4; k++) send_byte(8'(w0 >> (8 * k)));
      send_byte(8'(w1));
      send_byte(8'(w1 >> 8));
      reset      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'(w1 >> 16);
      tick();
      reset      = 1'b0;
      byte_valid = 1'b0;
      chk("abort_word0_written", 32'(exp_addr_q.size()), 32'd0);
      check_reset_state();
      w = '{$urandom};
      load_frame(w, 0, 1);

`ifdef IMEM_BOOT_CHECKSUM_EN
      // Good checksum: 01 00 01 02 03 04 F5
      do_reset();
      w = '{32'h0403_0201};
      load_frame(w, 0, 0);

      // Bad checksum still writes the data word, then errors
      do_reset();
      exp_addr_q.push_back(BASE);
      exp_data_q.push_back(32'h0403_0201);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'hF4);
      chk("chk_word_written", 32'(exp_addr_q.size()), 32'd0);
      chk("chk_error", 32'(error), 32'd1);
      tick();
      chk("chk_done", 32'(done), 32'd0);
      chk("chk_cpurst", 32'(cpu_reset), 32'd1);
`endif

      do_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
